uart_fifo_tx: RTL and testbench

UART_FIFO_TX -- requirements
Module: uart_fifo_tx

---
 rtl/uart_fifo_tx.sv | 139 +++++++++++++
 tb/tb_uart_fifo_tx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_tx.sv
// 8N1 UART transmitter draining a show-ahead FIFO; UART_FIFO_TX_PARITY_EN adds an even-parity bit (8E1).
// Latency: START begins 2 cycles after a pop is granted; backpressure: pops only from LOAD, when iEn=1 and iEmpty=0.
module uart_fifo_tx #(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 9600
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iEn,
  input  logic       iEmpty,
  input  logic [7:0] iRdData,
  output logic       oPop,
  output logic       oTx,
  output logic       oBusy,
  output logic       oDone
);

  // DIV must be at least 2 for the bit counter to be meaningful.
  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

`ifdef UART_FIFO_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, PARITY, STOP} stateT;
`else
  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} stateT;
`endif

  stateT         state, stateNxt;
  logic [CW-1:0] bitCnt, cntNxt;
  logic [2:0]    bitIdx, idxNxt;
  logic [7:0]    shiftReg, shNxt;
  logic          txQ, txNxt;
  logic          armed;
  logic          bitEnd;
`ifdef UART_FIFO_TX_PARITY_EN
  logic          parityQ;
`endif

  assign bitEnd = (bitCnt == LAST);

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state    <= IDLE;
      bitCnt   <= '0;
      bitIdx   <= '0;
      shiftReg <= '0;
      txQ      <= 1'b1;
      armed    <= 1'b0;
    end else begin
      state    <= stateNxt;
      bitCnt   <= cntNxt;
      bitIdx   <= idxNxt;
      shiftReg <= shNxt;
      txQ      <= txNxt;
      armed    <= 1'b1;
    end
  end

`ifdef UART_FIFO_TX_PARITY_EN
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst)
      parityQ <= 1'b0;
    else if (state == LOAD)
      parityQ <= ^iRdData;
  end
`endif

  always_comb begin
    stateNxt = state;
    cntNxt   = bitCnt;
    idxNxt   = bitIdx;
    shNxt    = shiftReg;
    txNxt    = 1'b1;
    case (state)
      // armed holds off the first LOAD until the second edge after reset release
      IDLE: if (armed && iEn && !iEmpty) stateNxt = LOAD;
      LOAD: begin
        shNxt    = iRdData;
        cntNxt   = '0;
        stateNxt = START;
      end
      START: begin
        cntNxt = bitCnt + CW'(1);
        if (bitEnd) begin
          cntNxt   = '0;
          idxNxt   = '0;
          stateNxt = DATA;
        end
      end
      DATA: begin
        cntNxt = bitCnt + CW'(1);
        if (bitEnd) begin
          cntNxt = '0;
          shNxt  = {1'b0, shiftReg[7:1]};
          idxNxt = bitIdx + 3'd1;
`ifdef UART_FIFO_TX_PARITY_EN
          if (bitIdx == 3'd7) stateNxt = PARITY;
`else
          if (bitIdx == 3'd7) stateNxt = STOP;
`endif
        end
      end
`ifdef UART_FIFO_TX_PARITY_EN
      PARITY: begin
        cntNxt = bitCnt + CW'(1);
        if (bitEnd) begin
          cntNxt   = '0;
          stateNxt = STOP;
        end
      end
`endif
      STOP: begin
        cntNxt = bitCnt + CW'(1);
        if (bitEnd) begin
          cntNxt   = '0;
          stateNxt = IDLE;
        end
      end
      default: stateNxt = IDLE;
    endcase

    // Line level is computed for the state being entered so the flop tracks state exactly.
    case (stateNxt)
      START:   txNxt = 1'b0;
      DATA:    txNxt = shNxt[0];
`ifdef UART_FIFO_TX_PARITY_EN
      PARITY:  txNxt = parityQ;
`endif
      default: txNxt = 1'b1;
    endcase
  end

  assign oTx   = txQ;
  assign oPop  = (state == LOAD);
  assign oBusy = (state != IDLE);
  assign oDone = (state == STOP) && bitEnd;

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Directed bench for uart_fifo_tx at DIV=16 with a queue standing in for the upstream FIFO.
module tb_uart_fifo_tx;

`ifdef UART_FIFO_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       iClk = 1'b0;
  logic       iRst, iEn, iEmpty;
  logic [7:0] iRdData;
  logic       oPop, oTx, oBusy, oDone;

  int nCmp = 0;
  int nErr = 0;
  int popCount = 0;
  logic [7:0] q[$];

  always #5 iClk = ~iClk;

  uart_fifo_tx #(.CLK_HZ(16), .BAUD(1)) dut (
    .iClk(iClk), .iRst(iRst), .iEn(iEn), .iEmpty(iEmpty), .iRdData(iRdData),
    .oPop(oPop), .oTx(oTx), .oBusy(oBusy), .oDone(oDone)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic expBit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (k == 9 && NB == 11) return ^b;
    return 1'b1;
  endfunction

  task automatic drive();
    iEmpty  = (q.size() == 0);
    iRdData = (q.size() != 0) ? q[0] : 8'h00;
  endtask

  // Outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    logic p;
    p = oPop;
    @(posedge iClk);
    #1;
    if (p === 1'b1) begin
      popCount++;
      if (q.size() != 0) void'(q.pop_front());
    end
    drive();
  endtask

  task automatic runFrame(input logic [7:0] b, input int dropAt, output int gap);
    logic [31:0] obs;
    int doneErr, busyErr;
    gap = 0;
    doneErr = 0;
    busyErr = 0;
    while (oTx !== 1'b0 && gap < 300) begin
      tick();
      gap++;
    end
    if (gap >= 300) begin
      chk("start_timeout", 32'(gap), 32'd0);
      return;
    end
    for (int k = 0; k < NB; k++) begin
      obs = '0;
      for (int c = 0; c < 16; c++) begin
        obs[c] = oTx;
        if (oDone !== ((k == NB-1) && (c == 15))) doneErr++;
        if (oBusy !== 1'b1) busyErr++;
        if (k*16 + c == dropAt) iEn = 1'b0;
        tick();
      end
      chk($sformatf("byte%02h_bit%0d", b, k), obs, expBit(b, k) ? 32'h0000FFFF : 32'h0);
    end
    chk($sformatf("byte%02h_done", b), 32'(doneErr), 32'd0);
    chk($sformatf("byte%02h_busy", b), 32'(busyErr), 32'd0);
    chk($sformatf("byte%02h_end_idle", b), 32'(oBusy), 32'd0);
  endtask

  initial begin
    int gap, badTx, badPop, badBusy, doneSeen;
    iRst = 1'b1;
    iEn  = 1'b0;
    drive();
    #1;
    chk("rst_tx", 32'(oTx), 32'd1);
    chk("rst_pop", 32'(oPop), 32'd0);
    chk("rst_busy", 32'(oBusy), 32'd0);
    chk("rst_done", 32'(oDone), 32'd0);
    tick();
    tick();
    iRst = 1'b0;

    // Empty FIFO with enable high: line stays idle
    iEn = 1'b1;
    badTx = 0; badPop = 0; badBusy = 0;
    for (int i = 0; i < 500; i++) begin
      if (oTx !== 1'b1) badTx++;
      if (oPop !== 1'b0) badPop++;
      if (oBusy !== 1'b0) badBusy++;
      tick();
    end
    chk("empty_tx", 32'(badTx), 32'd0);
    chk("empty_pop", 32'(badPop), 32'd0);
    chk("empty_busy", 32'(badBusy), 32'd0);

    // Single byte 0xA5
    popCount = 0;
    q.push_back(8'hA5);
    drive();
    runFrame(8'hA5, -1, gap);
    for (int i = 0; i < 20; i++) tick();
    chk("a5_pops", 32'(popCount), 32'd1);
    chk("a5_fifo_left", 32'(q.size()), 32'd0);

    // Three queued bytes, back to back
    popCount = 0;
    q.push_back(8'h00);
    q.push_back(8'hFF);
    q.push_back(8'h55);
    drive();
    runFrame(8'h00, -1, gap);
    runFrame(8'hFF, -1, gap);
    chk("b2b_gap_ff", 32'(gap), 32'd2);
    runFrame(8'h55, -1, gap);
    chk("b2b_gap_55", 32'(gap), 32'd2);
    for (int i = 0; i < 50; i++) tick();
    chk("b2b_pops", 32'(popCount), 32'd3);
    chk("b2b_idle", 32'(oBusy), 32'd0);

    // Reset at cycle 50 of a 0x3C frame
    popCount = 0;
    q.push_back(8'h3C);
    drive();
    gap = 0;
    while (oTx !== 1'b0 && gap < 300) begin
      tick();
      gap++;
    end
    chk("rst_frame_started", 32'(oTx), 32'd0);
    for (int i = 0; i < 50; i++) tick();
    iRst = 1'b1;
    #1;
    chk("midrst_tx", 32'(oTx), 32'd1);
    chk("midrst_busy", 32'(oBusy), 32'd0);
    chk("midrst_pop", 32'(oPop), 32'd0);
    doneSeen = 0;
    for (int i = 0; i < 3; i++) begin
      if (oDone !== 1'b0) doneSeen++;
      tick();
    end
    chk("midrst_no_done", 32'(doneSeen), 32'd0);
    chk("midrst_pops", 32'(popCount), 32'd1);
    q.push_back(8'h81);
    drive();
    iRst = 1'b0;
    tick();
    chk("rel_no_pop_edge1", 32'(oPop), 32'd0);
    runFrame(8'h81, -1, gap);
    chk("rel_start_late", 32'(gap >= 2), 32'd1);
    chk("rel_pops", 32'(popCount), 32'd2);

    // Enable low blocks pops; dropping it mid-frame finishes the frame only
    popCount = 0;
    iEn = 1'b0;
    q.push_back(8'h12);
    q.push_back(8'h34);
    drive();
    badBusy = 0;
    for (int i = 0; i < 100; i++) begin
      if (oBusy !== 1'b0) badBusy++;
      tick();
    end
    chk("en0_pops", 32'(popCount), 32'd0);
    chk("en0_busy", 32'(badBusy), 32'd0);
    iEn = 1'b1;
    runFrame(8'h12, 30, gap);
    for (int i = 0; i < 100; i++) tick();
    chk("endrop_pops", 32'(popCount), 32'd1);
    chk("endrop_fifo_left", 32'(q.size()), 32'd1);
    chk("endrop_idle", 32'(oBusy), 32'd0);
    q.delete();
    drive();

`ifdef UART_FIFO_TX_PARITY_EN
    popCount = 0;
    iEn = 1'b1;
    q.push_back(8'h07);
    q.push_back(8'h03);
    drive();
    runFrame(8'h07, -1, gap);
    runFrame(8'h03, -1, gap);
    chk("par_gap", 32'(gap), 32'd2);
    for (int i = 0; i < 20; i++) tick();
    chk("par_pops", 32'(popCount), 32'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
